// File: rtl/pcma_sym_aligner.sv
// Composite/hard-decision sample aligner for the PCMA compensator, plus the
// sequencer for the serial equalizer coefficient load.
module pcma_sym_aligner #(
    parameter int unsigned IQ_WIDTH   = 10,
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned EQ_LEN     = 19,
    parameter int unsigned COE_WIDTH  = 24
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            clear_err,
    input  logic                            comm_val,
    input  logic [NUM_CH*IQ_WIDTH-1:0]      comm_I,
    input  logic [NUM_CH*IQ_WIDTH-1:0]      comm_Q,
    input  logic                            hd_val,
    input  logic [NUM_CH*IQ_WIDTH-1:0]      hd_I,
    input  logic [NUM_CH*IQ_WIDTH-1:0]      hd_Q,
    output logic                            o_val,
    output logic [NUM_CH*IQ_WIDTH-1:0]      o_comm_I,
    output logic [NUM_CH*IQ_WIDTH-1:0]      o_comm_Q,
    output logic [NUM_CH*IQ_WIDTH-1:0]      o_hd_I,
    output logic [NUM_CH*IQ_WIDTH-1:0]      o_hd_Q,
    output logic [$clog2(FIFO_DEPTH):0]     o_level,
    output logic                            o_ovf,
    output logic                            o_unf,
    input  logic                            load_start,
    input  logic                            coe_val,
    input  logic [COE_WIDTH-1:0]            coe_in,
    output logic                            o_coe_we,
    output logic [$clog2(EQ_LEN)-1:0]       o_coe_addr,
    output logic [COE_WIDTH-1:0]            o_coe_data,
    output logic                            o_coe_busy,
    output logic                            o_coe_done,
    output logic                            o_coe_err
);

    localparam int unsigned W  = NUM_CH * IQ_WIDTH;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(EQ_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } coe_state_e;

    // ---------------- composite FIFO ----------------
    logic [2*W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           empty, full, push, pop;
    logic [2*W-1:0] wr_word, head_word;

    always_comb begin
        empty     = (level_q == '0);
        full      = (level_q == LW'(FIFO_DEPTH));
        pop       = hd_val && !empty && !flush;
        // a simultaneous pop frees the slot, so a push at full still proceeds
        push      = comm_val && (!full || pop) && !flush;
        wr_word   = {comm_Q, comm_I};
        head_word = mem_q[rd_ptr_q];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // ---------------- paired output stage ----------------
    logic         val_q, val_d;
    logic [W-1:0] comm_i_q, comm_i_d, comm_q_q, comm_q_d;
    logic [W-1:0] hd_i_q, hd_i_d, hd_q_q, hd_q_d;
    logic         ovf_q, ovf_d, unf_q, unf_d;
    logic         ovf_set, unf_set;

    always_comb begin
        val_d    = pop;
        comm_i_d = comm_i_q;
        comm_q_d = comm_q_q;
        hd_i_d   = hd_i_q;
        hd_q_d   = hd_q_q;
        if (pop) begin
            comm_i_d = head_word[W-1:0];
            comm_q_d = head_word[2*W-1:W];
            hd_i_d   = hd_I;
            hd_q_d   = hd_Q;
        end
        ovf_set = !flush && comm_val && full && !pop;
        unf_set = !flush && hd_val && empty;
        ovf_d   = ovf_set || (ovf_q && !clear_err);
        unf_d   = unf_set || (unf_q && !clear_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q    <= 1'b0;
            comm_i_q <= '0;
            comm_q_q <= '0;
            hd_i_q   <= '0;
            hd_q_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            val_q    <= val_d;
            comm_i_q <= comm_i_d;
            comm_q_q <= comm_q_d;
            hd_i_q   <= hd_i_d;
            hd_q_q   <= hd_q_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign o_val    = val_q;
    assign o_comm_I = comm_i_q;
    assign o_comm_Q = comm_q_q;
    assign o_hd_I   = hd_i_q;
    assign o_hd_Q   = hd_q_q;
    assign o_level  = level_q;
    assign o_ovf    = ovf_q;
    assign o_unf    = unf_q;

    // ---------------- coefficient load sequencer ----------------
    coe_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [CW-1:0]          addr_q, addr_d;
    logic [COE_WIDTH-1:0]   data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   err_set;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_set = 1'b0;
        // load_start outranks coe_val; the concurrent word is discarded
        if (load_start) begin
            if (state_q == S_LOAD) err_set = 1'b1;
            state_d = S_LOAD;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else if (coe_val) begin
            if (state_q == S_LOAD) begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = coe_in;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(EQ_LEN - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end else begin
                err_set = 1'b1;
            end
        end
        err_d = err_set || (err_q && !clear_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_coe_we   = we_q;
    assign o_coe_addr = addr_q;
    assign o_coe_data = data_q;
    assign o_coe_busy = busy_q;
    assign o_coe_done = done_q;
    assign o_coe_err  = err_q;

endmodule

// File: tb/tb_pcma_sym_aligner.sv
// Randomised and directed bench for pcma_sym_aligner against a queue-based
// reference model; compared every cycle on the falling edge.
module tb_pcma_sym_aligner;

    localparam int unsigned IQ_WIDTH   = 10;
    localparam int unsigned NUM_CH     = 2;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned EQ_LEN     = 19;
    localparam int unsigned COE_WIDTH  = 24;
    localparam int unsigned W  = NUM_CH * IQ_WIDTH;
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW = $clog2(EQ_LEN);

    logic clk = 1'b0;
    logic reset, flush, clear_err, comm_val, hd_val, load_start, coe_val;
    logic [W-1:0] comm_I, comm_Q, hd_I, hd_Q;
    logic [COE_WIDTH-1:0] coe_in;
    logic o_val, o_ovf, o_unf, o_coe_we, o_coe_busy, o_coe_done, o_coe_err;
    logic [W-1:0] o_comm_I, o_comm_Q, o_hd_I, o_hd_Q;
    logic [LW-1:0] o_level;
    logic [CW-1:0] o_coe_addr;
    logic [COE_WIDTH-1:0] o_coe_data;

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    pcma_sym_aligner #(
        .IQ_WIDTH(IQ_WIDTH), .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH),
        .EQ_LEN(EQ_LEN), .COE_WIDTH(COE_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .clear_err(clear_err),
        .comm_val(comm_val), .comm_I(comm_I), .comm_Q(comm_Q),
        .hd_val(hd_val), .hd_I(hd_I), .hd_Q(hd_Q),
        .o_val(o_val), .o_comm_I(o_comm_I), .o_comm_Q(o_comm_Q),
        .o_hd_I(o_hd_I), .o_hd_Q(o_hd_Q), .o_level(o_level),
        .o_ovf(o_ovf), .o_unf(o_unf),
        .load_start(load_start), .coe_val(coe_val), .coe_in(coe_in),
        .o_coe_we(o_coe_we), .o_coe_addr(o_coe_addr), .o_coe_data(o_coe_data),
        .o_coe_busy(o_coe_busy), .o_coe_done(o_coe_done), .o_coe_err(o_coe_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2*W-1:0] mq[$];
    logic [2*W-1:0] m_head;
    bit m_val, m_ovf, m_unf, m_err, m_we, m_busy, m_done, m_loading;
    bit m_pop, m_push, m_es;
    logic [W-1:0] m_cI, m_cQ, m_hI, m_hQ;
    int m_idx;
    logic [CW-1:0] m_addr;
    logic [COE_WIDTH-1:0] m_data;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_val = 0; m_ovf = 0; m_unf = 0; m_err = 0;
            m_cI = '0; m_cQ = '0; m_hI = '0; m_hQ = '0;
            m_we = 0; m_busy = 0; m_done = 0; m_loading = 0; m_idx = 0;
            m_addr = '0; m_data = '0;
        end else begin
            m_val = 0;
            if (flush) begin
                mq.delete();
            end else begin
                m_pop  = hd_val && (mq.size() > 0);
                m_push = comm_val && (mq.size() < FIFO_DEPTH || m_pop);
                if (hd_val && mq.size() == 0) m_unf = 1;
                else if (clear_err) m_unf = 0;
                if (comm_val && mq.size() == FIFO_DEPTH && !m_pop) m_ovf = 1;
                else if (clear_err) m_ovf = 0;
                if (m_pop) begin
                    m_head = mq.pop_front();
                    m_val = 1;
                    m_cI = m_head[W-1:0];
                    m_cQ = m_head[2*W-1:W];
                    m_hI = hd_I;
                    m_hQ = hd_Q;
                end
                if (m_push) mq.push_back({comm_Q, comm_I});
            end
            if (flush && clear_err) begin
                m_ovf = 0;
                m_unf = 0;
            end
            m_we = 0;
            m_es = 0;
            if (load_start) begin
                if (m_loading) m_es = 1;
                m_loading = 1; m_idx = 0; m_busy = 1; m_done = 0;
            end else if (coe_val) begin
                if (m_loading) begin
                    m_we = 1;
                    m_addr = CW'(m_idx);
                    m_data = coe_in;
                    m_idx++;
                    if (m_idx == EQ_LEN) begin
                        m_loading = 0; m_busy = 0; m_done = 1;
                    end
                end else begin
                    m_es = 1;
                end
            end
            m_err = m_es || (m_err && !clear_err);
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("o_val", 64'(o_val), 64'(m_val));
            chk("o_level", 64'(o_level), 64'(mq.size()));
            chk("o_ovf", 64'(o_ovf), 64'(m_ovf));
            chk("o_unf", 64'(o_unf), 64'(m_unf));
            chk("o_comm_I", 64'(o_comm_I), 64'(m_cI));
            chk("o_comm_Q", 64'(o_comm_Q), 64'(m_cQ));
            chk("o_hd_I", 64'(o_hd_I), 64'(m_hI));
            chk("o_hd_Q", 64'(o_hd_Q), 64'(m_hQ));
            chk("o_coe_we", 64'(o_coe_we), 64'(m_we));
            chk("o_coe_addr", 64'(o_coe_addr), 64'(m_addr));
            chk("o_coe_data", 64'(o_coe_data), 64'(m_data));
            chk("o_coe_busy", 64'(o_coe_busy), 64'(m_busy));
            chk("o_coe_done", 64'(o_coe_done), 64'(m_done));
            chk("o_coe_err", 64'(o_coe_err), 64'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; flush = 0; clear_err = 0; comm_val = 0; hd_val = 0;
        load_start = 0; coe_val = 0;
        hd_I = W'($urandom); hd_Q = W'($urandom); coe_in = COE_WIDTH'($urandom);
    endtask

    // channel c of comm_I carries k + 100*c so lane packing is visible
    task automatic set_comm(input int k);
        for (int c = 0; c < NUM_CH; c++)
            comm_I[c*IQ_WIDTH +: IQ_WIDTH] = IQ_WIDTH'(k + 100 * c);
        comm_Q = W'($urandom);
    endtask

    initial begin
        comm_I = '0; comm_Q = '0;
        idle();
        reset = 1;
        repeat (3) tick();
        en = 1;
        chk("reset_level", 64'(o_level), 64'd0);
        chk("reset_val", 64'(o_val), 64'd0);
        chk("reset_busy", 64'(o_coe_busy), 64'd0);
        reset = 0;

        // fixed 4-cycle hard-decision latency, samples 1..100
        for (int t = 0; t < 104; t++) begin
            idle();
            comm_val = (t < 100);
            set_comm(t + 1);
            hd_val = (t >= 4);
            tick();
            if (t == 4) begin
                chk("lat_first_val", 64'(o_val), 64'd1);
                chk("lat_first_comm", 64'(o_comm_I[IQ_WIDTH-1:0]), 64'd1);
            end
            if (t == 50) chk("lat_level4", 64'(o_level), 64'd4);
        end
        chk("lat_no_ovf", 64'(o_ovf), 64'd0);
        chk("lat_no_unf", 64'(o_unf), 64'd0);

        // overflow: 17 pushes into 16 slots, then drain
        for (int k = 1; k <= 17; k++) begin
            idle(); comm_val = 1; set_comm(k); tick();
        end
        chk("ovf_level16", 64'(o_level), 64'd16);
        chk("ovf_flag", 64'(o_ovf), 64'd1);
        for (int k = 1; k <= 16; k++) begin
            idle(); hd_val = 1; tick();
            if (k == 16) chk("drain_last", 64'(o_comm_I[IQ_WIDTH-1:0]), 64'd16);
        end
        chk("drain_level0", 64'(o_level), 64'd0);
        idle(); clear_err = 1; tick();
        chk("ovf_cleared", 64'(o_ovf), 64'd0);

        // underflow with a simultaneous push: no fall-through
        idle(); hd_val = 1; comm_val = 1; set_comm(5); tick();
        chk("unf_no_val", 64'(o_val), 64'd0);
        chk("unf_flag", 64'(o_unf), 64'd1);
        chk("unf_level1", 64'(o_level), 64'd1);
        idle(); hd_val = 1; tick();
        chk("unf_next_val", 64'(o_val), 64'd1);
        chk("unf_next_comm", 64'(o_comm_I[IQ_WIDTH-1:0]), 64'd5);
        idle(); clear_err = 1; tick();
        chk("unf_cleared", 64'(o_unf), 64'd0);

        // full FIFO, push+pop every cycle, then flush
        for (int k = 0; k < 16; k++) begin
            idle(); comm_val = 1; set_comm(k + 10); tick();
        end
        for (int k = 0; k < 50; k++) begin
            idle(); comm_val = 1; hd_val = 1; set_comm(k + 40); tick();
        end
        chk("full_level16", 64'(o_level), 64'd16);
        chk("full_no_ovf", 64'(o_ovf), 64'd0);
        idle(); flush = 1; comm_val = 1; hd_val = 1; tick();
        chk("flush_level0", 64'(o_level), 64'd0);
        chk("flush_no_val", 64'(o_val), 64'd0);

        // coefficient load with random gaps
        idle(); load_start = 1; tick();
        chk("coe_busy", 64'(o_coe_busy), 64'd1);
        for (int k = 0; k < EQ_LEN; k++) begin
            repeat ($urandom_range(0, 3)) begin idle(); tick(); end
            idle(); coe_val = 1; tick();
        end
        chk("coe_last_we", 64'(o_coe_we), 64'd1);
        chk("coe_last_addr", 64'(o_coe_addr), 64'(EQ_LEN - 1));
        chk("coe_done", 64'(o_coe_done), 64'd1);
        chk("coe_done_busy", 64'(o_coe_busy), 64'd0);
        idle(); coe_val = 1; tick();
        chk("coe_extra_we", 64'(o_coe_we), 64'd0);
        chk("coe_extra_err", 64'(o_coe_err), 64'd1);
        idle(); clear_err = 1; tick();

        // restart mid-load, then reset mid-load
        idle(); load_start = 1; tick();
        for (int k = 0; k < 7; k++) begin idle(); coe_val = 1; tick(); end
        idle(); load_start = 1; tick();
        chk("restart_err", 64'(o_coe_err), 64'd1);
        for (int k = 0; k < 10; k++) begin
            idle(); coe_val = 1; tick();
            if (k == 0) chk("restart_addr0", 64'(o_coe_addr), 64'd0);
        end
        idle(); reset = 1; tick();
        chk("rst_busy", 64'(o_coe_busy), 64'd0);
        chk("rst_done", 64'(o_coe_done), 64'd0);
        for (int k = 0; k < 3; k++) begin
            idle(); coe_val = 1; tick();
            chk("rst_no_we", 64'(o_coe_we), 64'd0);
        end

        // random traffic on both paths
        for (int t = 0; t < 3000; t++) begin
            idle();
            comm_val   = ($urandom_range(0, 99) < 60);
            hd_val     = ($urandom_range(0, 99) < 55);
            flush      = ($urandom_range(0, 99) < 1);
            clear_err  = ($urandom_range(0, 99) < 3);
            load_start = ($urandom_range(0, 99) < 2);
            coe_val    = ($urandom_range(0, 99) < 40);
            reset      = ($urandom_range(0, 999) < 2);
            comm_I = W'($urandom);
            comm_Q = W'($urandom);
            tick();
        end

        idle();
        tick();
        en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcma_sym_aligner.md
Name: pcma_sym_aligner

Overview:
- Parametrised successor to the fixed-delay composite/hard-decision alignment front end of the PCMA compensator.
- Buffers composite IQ samples (NUM_CH channels) in a FIFO and pairs each with its hard-decoded reference when it arrives, so hard-decoder latency may vary and valid may have gaps.
- Also sequences the serial equalizer coefficient load (address counter, done/error flags).
- Sits between the hard decoder and the equalizer.

Parameters:
IQ_WIDTH, 10, bits per I or Q sample per channel
NUM_CH, 1, channels packed side by side, channel 0 in LSBs
FIFO_DEPTH, 16, composite buffer depth; power of two, >=4
EQ_LEN, 19, number of equalizer coefficients per load
COE_WIDTH, 24, full coefficient width (coe + inverse coe)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  clear FIFO contents
clear_err  in  1  clear sticky error flags
comm_val  in  1  composite sample valid (push)
comm_I  in  NUM_CH*IQ_WIDTH  composite I
comm_Q  in  NUM_CH*IQ_WIDTH  composite Q
hd_val  in  1  hard-decision valid (pop)
hd_I  in  NUM_CH*IQ_WIDTH  hard-decision I
hd_Q  in  NUM_CH*IQ_WIDTH  hard-decision Q
o_val  out  1  paired output valid
o_comm_I  out  NUM_CH*IQ_WIDTH  aligned composite I
o_comm_Q  out  NUM_CH*IQ_WIDTH  aligned composite Q
o_hd_I  out  NUM_CH*IQ_WIDTH  registered hard-decision I
o_hd_Q  out  NUM_CH*IQ_WIDTH  registered hard-decision Q
o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_ovf  out  1  sticky overflow
o_unf  out  1  sticky underflow
load_start  in  1  begin coefficient load
coe_val  in  1  coefficient word valid
coe_in  in  COE_WIDTH  coefficient word
o_coe_we  out  1  coefficient write strobe
o_coe_addr  out  $clog2(EQ_LEN)  coefficient index
o_coe_data  out  COE_WIDTH  coefficient data
o_coe_busy  out  1  load in progress
o_coe_done  out  1  full set loaded
o_coe_err  out  1  sticky protocol error

Behaviour:
- Reset: every output is 0, pointers and level are 0, FSM is in IDLE.
- Push: comm_val & !full writes one word. comm_val & full drops the sample and sets o_ovf.
- Pop: hd_val & !empty reads the FIFO head. One cycle later: o_val=1, o_comm_* = head, o_hd_* = hd_* captured that cycle. Latency is 1 cycle from hd_val.
- hd_val & empty: no output, o_unf set. There is no fall-through, even with a push in the same cycle.
- Push and pop together at full: both proceed, level unchanged, no ovf.
- Push and pop together at non-empty: level unchanged.
- o_level and the pointers update on the same edge. Pointers wrap modulo FIFO_DEPTH.
- flush has priority over push/pop: pointers and level go to 0, o_val=0 next cycle, sticky flags are not affected.
- Sticky flags: a set in the same cycle as clear_err wins. Otherwise clear_err clears o_ovf, o_unf and o_coe_err.
- o_comm_* and o_hd_* hold their values when o_val=0.
- Coefficient FSM states: IDLE, LOAD, DONE.
  - IDLE or DONE + load_start -> LOAD. addr counter=0, o_coe_busy=1, o_coe_done=0.
  - In LOAD, each coe_val produces, next cycle: o_coe_we=1 (one cycle), o_coe_addr=counter, o_coe_data=coe_in. Then counter+1.
  - On the EQ_LEN-th word -> DONE. o_coe_busy=0 and o_coe_done=1 in the same cycle as the last o_coe_we. o_coe_done holds until the next load_start.
  - load_start during LOAD: counter restarts at 0, o_coe_err set, stays in LOAD.
  - coe_val in IDLE or DONE: ignored, o_coe_err set.
  - load_start and coe_val in the same cycle: load_start wins and the word is ignored.
- reset mid-load returns the FSM to IDLE with all coefficient outputs 0. The equalizer must treat any partial set as invalid.

Test Plan:
- Fixed 4-cycle hd latency, continuous comm_val, samples 1..100 -> o_val 1 cycle after each hd_val, o_comm_I = 1..100 in order, o_level steady at 4, no flags.
- 17 pushes, no pops (DEPTH=16) -> sample 17 dropped, o_level=16, o_ovf=1. Then 16 pops -> values 1..16 out, o_level=0.
- hd_val with empty FIFO plus simultaneous comm_val=5 -> o_val stays 0, o_unf=1, o_level=1. Next hd_val outputs o_comm=5. clear_err -> o_unf=0.
- Full FIFO with push and pop every cycle for 50 cycles -> o_level stays 16, o_ovf=0, ordering preserved. flush mid-stream -> o_level=0 next cycle.
- load_start, then 19 coe_val with random gaps -> o_coe_addr 0..18 with matching data, o_coe_done=1 on the 19th strobe. A 20th coe_val -> no strobe, o_coe_err=1.
- load_start after 7 words -> err=1, addr restarts at 0. reset after word 10 -> IDLE, busy=0, done=0, no further strobes.
